// File: rtl/tennis_pkg.sv
// tennis_pkg: FSM states, player encoding and score width shared by the rally engine
package tennis_pkg;
  typedef enum logic [2:0] {SERVE = 3'd0, TO_P2 = 3'd1, TO_P1 = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;
  localparam int SCORE_W = 4;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: registered rising-edge detector; ports clk, rst, btn (debounced level), press (one-cycle pulse)
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic prev;
  // History resets high so a button held through reset never counts as a press
  always_ff @(posedge clk) begin
    prev  <= rst ? 1'b1 : btn;
    press <= rst ? 1'b0 : btn & ~prev;
  end
endmodule

// File: rtl/tennis_rally_engine.sv
// tennis_rally_engine: LED tennis rally/scoring FSM; ports clk, reset_clk, btn_p1/btn_p2, serve_mode -> led, scores, game_over, winner, hit, state_dbg
module tennis_rally_engine
  import tennis_pkg::*;
#(
  parameter int N_LEDS      = 16,
  parameter int BASE_DIV    = 25000000,
  parameter int MAX_SPEED   = 3,
  parameter int WIN_SCORE   = 7,
  parameter int PAUSE_CYC   = 50000000,
  parameter int EARLY_FAULT = 1
) (
  input  logic               clk,
  input  logic               reset_clk,
  input  logic               btn_p1,
  input  logic               btn_p2,
  input  logic               serve_mode,
  output logic [N_LEDS-1:0]  led,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner,
  output logic               hit,
  output logic [2:0]         state_dbg
);
  localparam int PW = $clog2(N_LEDS);
  localparam int CW = $clog2(BASE_DIV + 1);
  localparam int LW = $clog2(MAX_SPEED + 2);
  localparam int QW = $clog2(PAUSE_CYC + 1);
  localparam logic [PW-1:0] TOP = PW'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] ONES = '1;
  state_t state, state_n;
  logic server, server_n, scorer, scorer_n, winner_n, hit_n;
  logic [PW-1:0] pos, pos_n;
  logic [LW-1:0] level, level_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [QW-1:0] pcnt, pcnt_n;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic p1, p2, tick_exp, rally, rx, at_end, win_now;
  btn_edge u_edge_p1 (.clk(clk), .rst(reset_clk), .btn(btn_p1), .press(p1));
  btn_edge u_edge_p2 (.clk(clk), .rst(reset_clk), .btn(btn_p2), .press(p2));
  assign tick_exp = cnt == CW'((BASE_DIV >> level) - 1);
  assign rally    = state == TO_P2 || state == TO_P1;
  // Only the receiving player's press matters during a rally
  assign rx       = state == TO_P1 ? p1 : p2;
  assign at_end   = pos == (state == TO_P1 ? TOP : '0);
  assign win_now  = (scorer == P1 ? score_p1 : score_p2) == SCORE_W'(WIN_SCORE);
  always_comb begin
    state_n  = state;
    server_n = server;
    pos_n    = pos;
    level_n  = level;
    s1_n     = score_p1;
    s2_n     = score_p2;
    scorer_n = scorer;
    winner_n = winner;
    hit_n    = 1'b0;
    pcnt_n   = '0;
    case (state)
      SERVE: if (server == P1 ? p1 : p2) begin
        state_n = server == P1 ? TO_P2 : TO_P1;
        pos_n   = server == P1 ? TOP : '0;
        level_n = '0;
      end
      TO_P2, TO_P1:
        // A press at the end beats a simultaneous tick expiry
        if (rx && at_end) begin
          state_n = state == TO_P2 ? TO_P1 : TO_P2;
          level_n = level == LW'(MAX_SPEED) ? level : level + 1'b1;
          hit_n   = 1'b1;
        end else if ((rx && EARLY_FAULT != 0) || (tick_exp && at_end)) begin
          state_n  = POINT;
          scorer_n = state == TO_P2 ? P1 : P2;
          s1_n     = state == TO_P2 ? score_p1 + 1'b1 : score_p1;
          s2_n     = state == TO_P1 ? score_p2 + 1'b1 : score_p2;
          level_n  = '0;
        end else if (tick_exp)
          pos_n = state == TO_P2 ? pos - 1'b1 : pos + 1'b1;
      POINT: begin
        pcnt_n = pcnt + 1'b1;
        if (pcnt == QW'(PAUSE_CYC - 1)) begin
          pcnt_n   = '0;
          state_n  = win_now ? OVER : SERVE;
          winner_n = win_now ? scorer : winner;
          server_n = win_now ? server : serve_mode ? ~scorer : ~server;
        end
      end
      default: ;
    endcase
    cnt_n = (state_n != state || hit_n || tick_exp || !rally) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state    <= SERVE;
      server   <= P1;
      pos      <= TOP;
      level    <= '0;
      cnt      <= '0;
      pcnt     <= '0;
      score_p1 <= '0;
      score_p2 <= '0;
      scorer   <= P1;
      winner   <= P1;
      hit      <= 1'b0;
    end else begin
      state    <= state_n;
      server   <= server_n;
      pos      <= pos_n;
      level    <= level_n;
      cnt      <= cnt_n;
      pcnt     <= pcnt_n;
      score_p1 <= s1_n;
      score_p2 <= s2_n;
      scorer   <= scorer_n;
      winner   <= winner_n;
      hit      <= hit_n;
    end
  end
  assign led = state == POINT ? ONES
             : state == OVER  ? (winner == P1 ? ONES << (N_LEDS - N_LEDS / 2) : ONES >> (N_LEDS - N_LEDS / 2))
             : N_LEDS'(1) << (state == SERVE ? (server == P1 ? TOP : '0) : pos);
  assign game_over = state == OVER;
  assign state_dbg = state;
endmodule
